uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period arithmetic,
// used by both uart_rx and uart_tx.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

   // Clock cycles per serial bit (integer division, remainder dropped).
   function automatic int calc_pulse_width(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 so the line reads as idle while reset is applied.
module uart_rx_sync (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic dout
);

   logic meta;

   // Resolve metastability over two clock stages before the decoder sees the line.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         meta <= 1'b1;
         dout <= 1'b1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing (start, DATA_WIDTH data bits LSB first,
// one stop bit) with a valid/ready output and frame-error/overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3
// vote over the samples one clock before, at and after the nominal point.
// The decoder always works one tap behind the synchronizer so that the
// "after" sample exists at the nominal point; both builds share that timing.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 115200,
   parameter int CLK_FREQ   = 100_000_000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  uart_in,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int PULSE_WIDTH = calc_pulse_width(CLK_FREQ, BAUD_RATE);
   localparam int HALF        = PULSE_WIDTH / 2;
   localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

   logic                  line_sync;
   logic                  line_d1;
   logic                  line_d2;
   logic [2:0]            settle;
   logic                  armed;
   logic                  bit_val;
   rx_state_t             state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] shift;
   logic                  load_pend;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rstn (rstn),
      .din  (uart_in),
      .dout (line_sync)
   );

   // Two delay taps: line_d1 is the nominal sample, line_d2 the one before it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         line_d1 <= 1'b1;
         line_d2 <= 1'b1;
      end else begin
         line_d1 <= line_sync;
         line_d2 <= line_d1;
      end
   end

   // Hold off edge detection until every tap carries a post-reset sample, so a
   // line that was already low is not mistaken for a fresh start bit.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         settle <= 3'd0;
      end else if (!armed) begin
         settle <= settle + 3'd1;
      end
   end

   assign armed = (settle == 3'd4);

`ifdef UART_RX_MAJORITY_EN
   assign bit_val = (line_d2 & line_d1) | (line_d2 & line_sync) | (line_d1 & line_sync);
`else
   assign bit_val = line_d1;
`endif

   // Frame decoder: finds the start edge, samples at bit centres, checks the stop bit.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         load_pend <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         load_pend <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (armed && line_d2 && !line_d1) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_TC) begin
                  cnt   <= '0;
                  state <= bit_val ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == PULSE_TC) begin
                  cnt   <= '0;
                  shift <= {bit_val, shift[DATA_WIDTH-1:1]};
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt == PULSE_TC) begin
                  cnt <= '0;
                  if (bit_val) begin
                     load_pend <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_IDLE: begin
               if (line_d1) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output holding register: a finished word always loads (reception never
   // stalls); overrun flags only a word that was never handed over.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load_pend) begin
            data    <= shift;
            valid   <= 1'b1;
            overrun <= valid && !ready;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Bit period is scaled down (16 clocks) so the
// full byte sweep fits in a short run. Frames are built from a byte value and a
// stop-bit value; received words are collected from valid/ready handshakes and
// compared with a queue of words the frame rules say should arrive.
module tb_uart_rx;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int PW       = CLK_FREQ / BAUD;
   localparam int HALF     = PW / 2;

   logic       clk     = 1'b0;
   logic       rstn    = 1'b0;
   logic       uart_in = 1'b1;
   logic       ready   = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   int checks      = 0;
   int errors      = 0;
   int err_pulses  = 0;
   int ovr_pulses  = 0;
   int e0;
   int o0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   uart_rx #(
      .DATA_WIDTH (8),
      .BAUD_RATE  (BAUD),
      .CLK_FREQ   (CLK_FREQ)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .uart_in   (uart_in),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Observe the output side away from the rising edge: handshakes and pulses.
   always @(negedge clk) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) err_pulses++;
      if (overrun) ovr_pulses++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      uart_in = 1'b1;
      repeat (n) tick();
   endtask

   // Drive one frame; optionally invert the line for one clock at the centre of
   // data bit glitch_bit, or pulse reset for one clock at the centre of data bit reset_bit.
   task automatic applyStimulus(input logic [7:0] value, input logic stop_bit,
                                input int glitch_bit, input int reset_bit);
      logic [9:0] frame;
      frame = {stop_bit, value, 1'b0};
      for (int c = 0; c < 10 * PW; c++) begin
         uart_in = frame[4'(c / PW)];
         if (glitch_bit >= 0 && c == HALF + (glitch_bit + 1) * PW) uart_in = ~uart_in;
         rstn = !(reset_bit >= 0 && c == HALF + (reset_bit + 1) * PW);
         tick();
      end
      uart_in = 1'b1;
      rstn    = 1'b1;
   endtask

   task automatic compareWords(input string tag);
      int n;
      checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      int         gap;
      int         glen;
      logic [7:0] glitch_exp;

      #1;
      rstn    = 1'b0;
      uart_in = 1'b1;
      ready   = 1'b0;
      repeat (3) tick();
      checkOutput("reset_valid", 32'(valid), 32'd0);
      checkOutput("reset_data", 32'(data), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      rstn = 1'b1;
      idle(2 * PW);

      // Every byte value, frames back to back, consumer always ready.
      ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(8'(i), 1'b1, -1, -1);
         exp_q.push_back(8'(i));
      end
      idle(2 * PW);
      compareWords("sweep");
      checkOutput("sweep_frame_err", 32'(err_pulses), 32'd0);
      checkOutput("sweep_overrun", 32'(ovr_pulses), 32'd0);

      // Random bytes, random idle gaps, occasional short false start before a frame.
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            glen = int'($urandom_range(1, HALF - 2));
            uart_in = 1'b0;
            repeat (glen) tick();
            idle(PW + 2);
         end
         applyStimulus(b, 1'b1, -1, -1);
         exp_q.push_back(b);
         gap = int'($urandom_range(0, 3 * PW));
         idle(gap);
      end
      idle(2 * PW);
      compareWords("random");
      checkOutput("random_frame_err", 32'(err_pulses), 32'd0);
      checkOutput("random_overrun", 32'(ovr_pulses), 32'd0);

      // Low pulse shorter than half a bit: rejected as a glitch, then 0x3C.
      e0 = err_pulses;
      uart_in = 1'b0;
      repeat (HALF - 2) tick();
      idle(2 * PW);
      checkOutput("glitch_valid", 32'(valid), 32'd0);
      checkOutput("glitch_frame_err", 32'(err_pulses - e0), 32'd0);
      compareWords("glitch_none");
      applyStimulus(8'h3C, 1'b1, -1, -1);
      exp_q.push_back(8'h3C);
      idle(2 * PW);
      compareWords("after_glitch");

      // Bad stop bit followed by a long break: one frame error, no word.
      e0 = err_pulses;
      applyStimulus(8'hA5, 1'b0, -1, -1);
      uart_in = 1'b0;
      repeat (20 * PW) tick();
      checkOutput("break_frame_err", 32'(err_pulses - e0), 32'd1);
      checkOutput("break_valid", 32'(valid), 32'd0);
      idle(2 * PW);
      compareWords("break_none");
      applyStimulus(8'h5A, 1'b1, -1, -1);
      exp_q.push_back(8'h5A);
      idle(2 * PW);
      compareWords("after_break");

      // Two words with nobody consuming: second overwrites first with one overrun.
      ready = 1'b0;
      o0 = ovr_pulses;
      applyStimulus(8'h11, 1'b1, -1, -1);
      applyStimulus(8'h22, 1'b1, -1, -1);
      idle(2 * PW);
      checkOutput("ovr_data", 32'(data), 32'h22);
      checkOutput("ovr_valid", 32'(valid), 32'd1);
      checkOutput("ovr_pulses", 32'(ovr_pulses - o0), 32'd1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      checkOutput("ovr_valid_cleared", 32'(valid), 32'd0);
      checkOutput("ovr_data_held", 32'(data), 32'h22);
      exp_q.push_back(8'h22);
      compareWords("overrun");

      // Reset during data bit 4 of an all-zero frame (line low after reset), then 0x7E.
      ready = 1'b1;
      e0 = err_pulses;
      o0 = ovr_pulses;
      applyStimulus(8'h00, 1'b1, -1, 4);
      idle(2 * PW);
      checkOutput("abort_valid", 32'(valid), 32'd0);
      applyStimulus(8'h7E, 1'b1, -1, -1);
      exp_q.push_back(8'h7E);
      idle(2 * PW);
      compareWords("abort");
      checkOutput("abort_frame_err", 32'(err_pulses - e0), 32'd0);
      checkOutput("abort_overrun", 32'(ovr_pulses - o0), 32'd0);

      // One-clock inverted glitch at the centre of data bit 3 of 0x0F.
`ifdef UART_RX_MAJORITY_EN
      glitch_exp = 8'h0F;
`else
      glitch_exp = 8'h07;
`endif
      applyStimulus(8'h0F, 1'b1, 3, -1);
      exp_q.push_back(glitch_exp);
      idle(2 * PW);
      compareWords("bit_glitch");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
